// File: rtl/fdc_pkg.sv
// Shared types for the fetch/decode sequencer: FSM states, opcodes, ALU codes
// and the packed control bundle produced by the decoder.
package fdc_pkg;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_HALT   = 2'd3
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_SLL  = 4'h4;
    localparam logic [3:0] OP_SRL  = 4'h5;
    localparam logic [3:0] OP_ADDI = 4'h6;
    localparam logic [3:0] OP_LW   = 4'h7;
    localparam logic [3:0] OP_SW   = 4'h8;
    localparam logic [3:0] OP_BEQ  = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_SLL = 3'd4;
    localparam logic [2:0] ALU_SRL = 3'd5;

    typedef struct packed {
        logic       register_destination;
        logic       register_write;
        logic       memory_to_register;
        logic       memread;
        logic       memwrite;
        logic       alusrc;
        logic       branch;
        logic       jump;
        logic [2:0] aluop;
        logic       halt;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/fdc_decoder.sv
// Combinational opcode -> control bundle lookup; the parent registers the
// result during its DECODE cycle.
module fdc_decoder
    import fdc_pkg::*;
(
    input  logic [3:0] opcode,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = CTRL_NONE;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                ctrl.register_destination = 1'b1;
                ctrl.register_write       = 1'b1;
                ctrl.aluop                = opcode[2:0];
            end
            OP_SLL, OP_SRL: begin
                ctrl.register_destination = 1'b1;
                ctrl.register_write       = 1'b1;
                ctrl.alusrc               = 1'b1;
                ctrl.aluop                = (opcode == OP_SLL) ? ALU_SLL : ALU_SRL;
            end
            OP_ADDI: begin
                ctrl.register_write = 1'b1;
                ctrl.alusrc         = 1'b1;
                ctrl.aluop          = ALU_ADD;
            end
            OP_LW: begin
                ctrl.register_write     = 1'b1;
                ctrl.memread            = 1'b1;
                ctrl.memory_to_register = 1'b1;
                ctrl.alusrc             = 1'b1;
                ctrl.aluop              = ALU_ADD;
            end
            OP_SW: begin
                ctrl.memwrite = 1'b1;
                ctrl.alusrc   = 1'b1;
                ctrl.aluop    = ALU_ADD;
            end
            OP_BEQ: begin
                ctrl.branch = 1'b1;
                ctrl.aluop  = ALU_SUB;
            end
            OP_JMP:  ctrl.jump = 1'b1;
            OP_HALT: ctrl.halt = 1'b1;
            default: ctrl = CTRL_NONE;
        endcase
    end

endmodule

// File: rtl/fetch_decode_ctrl.sv
// Multi-cycle fetch/decode sequencer: owns the PC, fetches over a req/ready
// handshake, registers decoded controls and waits for exec_done.
// Optional retired-instruction counter enabled by defining FDC_PERF_CNT_EN.
module fetch_decode_ctrl
    import fdc_pkg::*;
#(
    parameter int                ADDR_W   = 8,
    parameter int                INSTR_W  = 16,
    parameter int                REG_AW   = 3,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                          clk,
    input  logic                          reset,
    output logic                          imem_req,
    output logic [ADDR_W-1:0]             imem_addr,
    input  logic                          imem_ready,
    input  logic [INSTR_W-1:0]            imem_data,
    output logic [ADDR_W-1:0]             pc_output,
    output logic [REG_AW-1:0]             rs_reg,
    output logic [REG_AW-1:0]             rt_rd_reg,
    output logic [INSTR_W-4-2*REG_AW-1:0] immediate,
    output logic [2:0]                    shiftbits,
    output logic                          register_destination,
    output logic                          register_write,
    output logic                          memory_to_register,
    output logic                          memread,
    output logic                          memwrite,
    output logic                          alusrc,
    output logic                          branch,
    output logic                          jump,
    output logic [2:0]                    aluop,
    output logic                          ctrl_valid,
    input  logic                          exec_done,
    input  logic                          branch_taken,
    output logic                          halted
`ifdef FDC_PERF_CNT_EN
    ,
    output logic [31:0]                   retired_cnt
`endif
);

    localparam int IMM_W = INSTR_W - 4 - 2 * REG_AW;

    state_t              r_state;
    state_t              w_state_next;
    logic [ADDR_W-1:0]   r_pc;
    logic [INSTR_W-1:0]  r_instr;
    ctrl_t               r_ctrl;
    ctrl_t               w_dec_ctrl;
    logic [REG_AW-1:0]   r_rs;
    logic [REG_AW-1:0]   r_rt_rd;
    logic [IMM_W-1:0]    r_imm;
    logic                r_ctrl_valid;
    logic                w_imem_req;
    logic                w_fetch_accept;
    logic                w_retire;
    logic [ADDR_W-1:0]   w_pc_inc;
    logic [ADDR_W-1:0]   w_pc_next;
    logic [ADDR_W-1:0]   w_jump_target;
    logic [ADDR_W-1:0]   w_imm_sext;

    fdc_decoder u_decoder (
        .opcode (r_instr[INSTR_W-1 -: 4]),
        .ctrl   (w_dec_ctrl)
    );

    // Jump targets are zero-extended, branch offsets sign-extended, both
    // truncated when the immediate is wider than the PC.
    if (IMM_W >= ADDR_W) begin : g_imm_wide
        assign w_jump_target = r_imm[ADDR_W-1:0];
        assign w_imm_sext    = r_imm[ADDR_W-1:0];
    end else begin : g_imm_narrow
        assign w_jump_target = {{(ADDR_W-IMM_W){1'b0}}, r_imm};
        assign w_imm_sext    = {{(ADDR_W-IMM_W){r_imm[IMM_W-1]}}, r_imm};
    end

    assign w_pc_inc = r_pc + ADDR_W'(1);

    always_comb begin
        w_pc_next = w_pc_inc;
        if (r_ctrl.jump) begin
            w_pc_next = w_jump_target;
        end else if (r_ctrl.branch && branch_taken) begin
            w_pc_next = w_pc_inc + w_imm_sext;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_imem_req     = 1'b0;
        w_fetch_accept = 1'b0;
        w_retire       = 1'b0;
        case (r_state)
            ST_FETCH: begin
                w_imem_req = 1'b1;
                if (imem_ready) begin
                    w_fetch_accept = 1'b1;
                    w_state_next   = ST_DECODE;
                end
            end
            ST_DECODE: w_state_next = w_dec_ctrl.halt ? ST_HALT : ST_EXEC;
            ST_EXEC: begin
                if (exec_done) begin
                    w_retire     = 1'b1;
                    w_state_next = ST_FETCH;
                end
            end
            ST_HALT:  w_state_next = ST_HALT;
            default:  w_state_next = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pc         <= RESET_PC;
            r_instr      <= '0;
            r_ctrl       <= CTRL_NONE;
            r_rs         <= '0;
            r_rt_rd      <= '0;
            r_imm        <= '0;
            r_ctrl_valid <= 1'b0;
        end else begin
            if (w_fetch_accept) begin
                r_instr <= imem_data;
            end
            if (r_state == ST_DECODE) begin
                r_ctrl       <= w_dec_ctrl;
                r_rs         <= r_instr[INSTR_W-5 -: REG_AW];
                r_rt_rd      <= r_instr[INSTR_W-5-REG_AW -: REG_AW];
                r_imm        <= r_instr[IMM_W-1:0];
                r_ctrl_valid <= !w_dec_ctrl.halt;
            end
            if (w_retire) begin
                r_pc         <= w_pc_next;
                r_ctrl_valid <= 1'b0;
            end
        end
    end

`ifdef FDC_PERF_CNT_EN
    logic [31:0] r_retired_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_retired_cnt <= '0;
        end else if (w_retire) begin
            r_retired_cnt <= r_retired_cnt + 32'd1;
        end
    end

    assign retired_cnt = r_retired_cnt;
`endif

    assign imem_req             = w_imem_req;
    assign imem_addr            = r_pc;
    assign pc_output            = r_pc;
    assign rs_reg               = r_rs;
    assign rt_rd_reg            = r_rt_rd;
    assign immediate            = r_imm;
    assign shiftbits            = r_imm[2:0];
    assign register_destination = r_ctrl.register_destination;
    assign register_write       = r_ctrl.register_write;
    assign memory_to_register   = r_ctrl.memory_to_register;
    assign memread              = r_ctrl.memread;
    assign memwrite             = r_ctrl.memwrite;
    assign alusrc               = r_ctrl.alusrc;
    assign branch               = r_ctrl.branch;
    assign jump                 = r_ctrl.jump;
    assign aluop                = r_ctrl.aluop;
    assign ctrl_valid           = r_ctrl_valid;
    assign halted               = r_ctrl.halt;

endmodule

// File: tb/tb_fetch_decode_ctrl.sv
// Directed bench for fetch_decode_ctrl with hand-computed controls and PCs.
// Define FDC_PERF_CNT_EN for both files to also check retired_cnt.
module tb_fetch_decode_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ready;
    logic [15:0] imem_data;
    logic [7:0]  pc_output;
    logic [2:0]  rs_reg;
    logic [2:0]  rt_rd_reg;
    logic [5:0]  immediate;
    logic [2:0]  shiftbits;
    logic        register_destination, register_write, memory_to_register;
    logic        memread, memwrite, alusrc, branch, jump;
    logic [2:0]  aluop;
    logic        ctrl_valid;
    logic        exec_done;
    logic        branch_taken;
    logic        halted;
`ifdef FDC_PERF_CNT_EN
    logic [31:0] retired_cnt;
`endif

    int total = 0;
    int bad   = 0;

    // {regdst, regwr, mem2reg, memread, memwrite, alusrc, branch, jump, aluop}
    logic [10:0] obs_ctrl;
    assign obs_ctrl = {register_destination, register_write, memory_to_register,
                       memread, memwrite, alusrc, branch, jump, aluop};

    localparam logic [10:0] C_ADD  = 11'b11000000_000;
    localparam logic [10:0] C_SUB  = 11'b11000000_001;
    localparam logic [10:0] C_AND  = 11'b11000000_010;
    localparam logic [10:0] C_OR   = 11'b11000000_011;
    localparam logic [10:0] C_SLL  = 11'b11000100_100;
    localparam logic [10:0] C_SRL  = 11'b11000100_101;
    localparam logic [10:0] C_ADDI = 11'b01000100_000;
    localparam logic [10:0] C_LW   = 11'b01110100_000;
    localparam logic [10:0] C_SW   = 11'b00001100_000;
    localparam logic [10:0] C_BEQ  = 11'b00000010_001;
    localparam logic [10:0] C_JMP  = 11'b00000001_000;
    localparam logic [10:0] C_NONE = 11'b00000000_000;

    fetch_decode_ctrl dut (
        .clk                  (clk),
        .reset                (reset),
        .imem_req             (imem_req),
        .imem_addr            (imem_addr),
        .imem_ready           (imem_ready),
        .imem_data            (imem_data),
        .pc_output            (pc_output),
        .rs_reg               (rs_reg),
        .rt_rd_reg            (rt_rd_reg),
        .immediate            (immediate),
        .shiftbits            (shiftbits),
        .register_destination (register_destination),
        .register_write       (register_write),
        .memory_to_register   (memory_to_register),
        .memread              (memread),
        .memwrite             (memwrite),
        .alusrc               (alusrc),
        .branch               (branch),
        .jump                 (jump),
        .aluop                (aluop),
        .ctrl_valid           (ctrl_valid),
        .exec_done            (exec_done),
        .branch_taken         (branch_taken),
        .halted               (halted)
`ifdef FDC_PERF_CNT_EN
        ,
        .retired_cnt          (retired_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered 1 time unit after an edge with the DUT in FETCH; leaves it the same way.
    task automatic run_instr(input string name, input logic [15:0] instr,
                             input logic [7:0] pc_now, input logic [10:0] exp_ctrl,
                             input logic taken, input logic [7:0] pc_after);
        chk({name, ".req"},  imem_req, 1'b1);
        chk({name, ".addr"}, imem_addr, pc_now);
        imem_data  = instr;
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        chk({name, ".dec_valid"}, ctrl_valid, 1'b0);
        chk({name, ".dec_req"},   imem_req, 1'b0);
        step();
        chk({name, ".valid"}, ctrl_valid, 1'b1);
        chk({name, ".ctrl"},  obs_ctrl, exp_ctrl);
        chk({name, ".rs"},    rs_reg, instr[11:9]);
        chk({name, ".rt"},    rt_rd_reg, instr[8:6]);
        chk({name, ".imm"},   immediate, instr[5:0]);
        chk({name, ".shamt"}, shiftbits, instr[2:0]);
        exec_done    = 1'b1;
        branch_taken = taken;
        step();
        exec_done    = 1'b0;
        branch_taken = 1'b0;
        chk({name, ".valid_off"}, ctrl_valid, 1'b0);
        chk({name, ".pc"},        pc_output, pc_after);
        chk({name, ".next_addr"}, imem_addr, pc_after);
        $display("txn %-6s instr=%04h pc=%02h -> %02h ctrl=%03h", name, instr, pc_now, pc_output, obs_ctrl);
    endtask

    initial begin
        reset        = 1'b0;
        imem_ready   = 1'b1;
        imem_data    = 16'h0A40;
        exec_done    = 1'b0;
        branch_taken = 1'b0;
        step();
        step();
        chk("rst.pc",     pc_output, 8'h00);
        chk("rst.valid",  ctrl_valid, 1'b0);
        chk("rst.halted", halted, 1'b0);
        chk("rst.ctrl",   obs_ctrl, C_NONE);
        chk("rst.rs",     rs_reg, 3'd0);
        reset = 1'b1;

        // ADD rs=5 rt=1 at address 0
        run_instr("ADD", 16'h0A40, 8'h00, C_ADD, 1'b0, 8'h01);

        // Fetch stall: request and address held while imem_ready is low
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall.req",   imem_req, 1'b1);
            chk("stall.addr",  imem_addr, 8'h01);
            chk("stall.valid", ctrl_valid, 1'b0);
        end
        $display("txn STALL  5 cycles at pc=01");
        run_instr("SLL",  16'h44C5, 8'h01, C_SLL,  1'b0, 8'h02);

        run_instr("JMP",  16'hA010, 8'h02, C_JMP,  1'b0, 8'h10);
        run_instr("BEQ_T",16'h92BD, 8'h10, C_BEQ,  1'b1, 8'h0E);
        run_instr("JMP",  16'hA010, 8'h0E, C_JMP,  1'b0, 8'h10);
        run_instr("BEQ_N",16'h92BD, 8'h10, C_BEQ,  1'b0, 8'h11);
        run_instr("JMP",  16'hA020, 8'h11, C_JMP,  1'b0, 8'h20);
        run_instr("JMP",  16'hA000, 8'h20, C_JMP,  1'b0, 8'h00);
        // Backward branch from 0 by -2 wraps to 0xFF, then sequential wrap to 0
        run_instr("BEQ_W",16'h903E, 8'h00, C_BEQ,  1'b1, 8'hFF);
        run_instr("ADDI", 16'h6247, 8'hFF, C_ADDI, 1'b0, 8'h00);
        run_instr("NOP",  16'hB000, 8'h00, C_NONE, 1'b0, 8'h01);
        run_instr("SW",   16'h8285, 8'h01, C_SW,   1'b0, 8'h02);

        // LW interrupted by reset in the middle of EXEC
        chk("lw.addr", imem_addr, 8'h02);
        imem_data  = 16'h7083;
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        step();
        chk("lw.valid", ctrl_valid, 1'b1);
        chk("lw.ctrl",  obs_ctrl, C_LW);
        reset = 1'b0;
        step();
        chk("lwrst.ctrl",  obs_ctrl, C_NONE);
        chk("lwrst.valid", ctrl_valid, 1'b0);
        chk("lwrst.pc",    pc_output, 8'h00);
        chk("lwrst.rt",    rt_rd_reg, 3'd0);
`ifdef FDC_PERF_CNT_EN
        chk("lwrst.cnt",   retired_cnt, 32'd0);
`endif
        $display("txn LW     reset during EXEC, pc=%02h", pc_output);
        reset = 1'b1;

        // Seven retired instructions, then HALT
        run_instr("SUB",  16'h1000, 8'h00, C_SUB,  1'b0, 8'h01);
        run_instr("AND",  16'h2000, 8'h01, C_AND,  1'b0, 8'h02);
        run_instr("OR",   16'h3000, 8'h02, C_OR,   1'b0, 8'h03);
        run_instr("SRL",  16'h5000, 8'h03, C_SRL,  1'b0, 8'h04);
        run_instr("ADD",  16'h0000, 8'h04, C_ADD,  1'b0, 8'h05);
        run_instr("NOP",  16'hC000, 8'h05, C_NONE, 1'b0, 8'h06);
        run_instr("BEQ_N",16'h9000, 8'h06, C_BEQ,  1'b0, 8'h07);

        chk("halt.addr", imem_addr, 8'h07);
        imem_data  = 16'hF000;
        imem_ready = 1'b1;
        step();
        chk("halt.dec_valid", ctrl_valid, 1'b0);
        exec_done = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("halt.halted", halted, 1'b1);
            chk("halt.req",    imem_req, 1'b0);
            chk("halt.pc",     pc_output, 8'h07);
            chk("halt.valid",  ctrl_valid, 1'b0);
        end
`ifdef FDC_PERF_CNT_EN
        chk("halt.cnt", retired_cnt, 32'd7);
`endif
        $display("txn HALT   pc=%02h halted=%0d for 20 cycles", pc_output, halted);
        exec_done  = 1'b0;
        imem_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_decode_ctrl.md
Name: fetch_decode_ctrl

Overview:
- Multi-cycle fetch/decode sequencer for the non-pipelined processor. Generalises the previous fixed PC → instruction memory → control unit wiring.
- Owns the PC register and runs a handshaked fetch from instruction memory.
- Decodes opcode and fields into registered control signals, then waits for datapath completion before advancing the PC.
- Adds over the fixed wiring: parametrised widths, branch/jump support, halt, and a per-instruction valid/done handshake.

Parameters:
- ADDR_W, 8, PC and instruction-memory address width.
- INSTR_W, 16, instruction width; must be ≥ 4 + 2*REG_AW + 3.
- REG_AW, 3, register-specifier width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- imem_req  out  1  fetch request; held until accepted.
- imem_addr  out  ADDR_W  fetch address, equals pc while imem_req=1.
- imem_ready  in  1  instruction valid; accepted when imem_req && imem_ready.
- imem_data  in  INSTR_W  instruction word.
- pc_output  out  ADDR_W  current PC.
- rs_reg  out  REG_AW  instr[INSTR_W-5 -: REG_AW].
- rt_rd_reg  out  REG_AW  next REG_AW bits below rs.
- immediate  out  INSTR_W-4-2*REG_AW  remaining low bits, raw.
- shiftbits  out  3  immediate[2:0].
- register_destination, register_write, memory_to_register, memread, memwrite, alusrc, branch, jump  out  1 each  decoded controls.
- aluop  out  3  ALU operation.
- ctrl_valid  out  1  controls and fields valid for the current instruction.
- exec_done  in  1  datapath finished the instruction; sampled only in EXEC.
- branch_taken  in  1  compare result; sampled with exec_done.
- halted  out  1  HALT executed.

Behaviour:
- Reset (reset=0 at a clk edge): overrides everything, including mid-fetch or mid-exec.
  - state=FETCH, pc=RESET_PC.
  - All control outputs, fields, ctrl_valid and halted = 0.
  - imem_req=1 from the first cycle after reset deasserts.
- States: FETCH, DECODE, EXEC, HALT.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - On imem_req && imem_ready: latch imem_data into the instruction register, go to DECODE.
  - No timeout; imem_ready may stay low indefinitely.
- DECODE (exactly 1 cycle):
  - Register fields and controls from the opcode table.
  - Go to EXEC; ctrl_valid=1 from the next cycle.
- EXEC:
  - ctrl_valid=1; outputs held stable.
  - On exec_done, update pc, then set ctrl_valid=0 and go to FETCH:
    - jump: pc = immediate zero-extended/truncated to ADDR_W.
    - branch && branch_taken: pc = pc+1+sign-extended immediate, modulo 2^ADDR_W.
    - otherwise: pc = pc+1, wrapping from all-ones to 0.
  - exec_done in the same cycle as the EXEC entry edge is not possible; exec_done outside EXEC is ignored.
- Minimum latency: FETCH→FETCH is 3 cycles with imem_ready=1 and exec_done=1 on the first EXEC cycle.
- HALT opcode: on DECODE, go to HALT.
  - halted=1, ctrl_valid=0, imem_req=0, pc frozen.
  - Left only by reset.
- Opcode table (opcode=instr[INSTR_W-1 -: 4]); aluop codes 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLL, 5 SRL:
  - 0 ADD, 1 SUB, 2 AND, 3 OR: register_destination=1, register_write=1, alusrc=0, aluop=opcode.
  - 4 SLL, 5 SRL: register_destination=1, register_write=1, alusrc=1, aluop=4/5.
  - 6 ADDI: register_write=1, alusrc=1, aluop=0.
  - 7 LW: register_write=1, memread=1, memory_to_register=1, alusrc=1, aluop=0.
  - 8 SW: memwrite=1, alusrc=1, aluop=0.
  - 9 BEQ: branch=1, aluop=1.
  - A JMP: jump=1.
  - F HALT.
  - Others: NOP, all controls 0, still goes through EXEC.
  - Unlisted controls are 0.

Optional Feature:
- Macro: FDC_PERF_CNT_EN.
- Defined:
  - Adds output retired_cnt (32 bits), reset to 0.
  - Increments on each exec_done accepted in EXEC; wraps.
  - HALT is not counted.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Package fdc_pkg:
  - state enum.
  - 4-bit opcode localparams.
  - 3-bit aluop localparams.
  - Packed control-bundle struct.
- One sub-module, fdc_decoder: purely combinational opcode → control bundle, registered by the parent in DECODE.

Test Plan:
- Reset with imem_ready=1, ADD at address 0 (instr 0x0A40), exec_done after 1 EXEC cycle → ctrl_valid=1 with register_write=1, aluop=0, rs=5, rt_rd=1; pc becomes 1; next imem_req at address 1.
- imem_ready held low 5 cycles in FETCH → imem_req stays 1, imem_addr stable, no state change; advances the cycle after imem_ready=1.
- BEQ at pc=0x10 with imm=-3 (0x3D):
  - branch_taken=1 → pc=0x0E.
  - branch_taken=0 → pc=0x11.
- JMP imm=0x20 → pc=0x20; straight-line execution from pc=0xFF → wraps to 0x00.
- HALT → halted=1, imem_req=0 for 20 cycles; reset=0 mid-EXEC of a LW → next cycle all controls 0, pc=RESET_PC.
- With FDC_PERF_CNT_EN, 7 instructions then HALT → retired_cnt=7.
